multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle FSM controller sequencing the MIPS datapath (PC, IR, RF, ALU, data memory).
//  Decodes the IR-held Instr per state; drives the same datapath selects/enables as the
//  single-cycle decoder plus IR load and a data-memory req/ack handshake.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles in MEM without Mem_Ack before fault (only with CTRL_MEM_TIMEOUT_EN)
// PORTS
//  Clk            in   1  clock, rising edge
//  Reset          in   1  synchronous, active-high reset
//  Instr          in   32 IR output; stable from DEC until return to IF
//  Zero           in   1  ALU zero flag, sampled in EX
//  Mem_Ack        in   1  data memory completion, 1-cycle pulse
//  Instr_LdEn     out  1  IR load enable
//  PC_sel         out  1  0=PC+4, 1=PC+4+(SignExt(imm)<<2)
//  PC_LdEn        out  1  PC write enable
//  RF_WrEn        out  1  register file write enable
//  RF_WrData_sel  out  1  0=ALU result, 1=memory data
//  RF_B_sel       out  1  0=Instr[15:11], 1=Instr[20:16]
//  ALU_Bin_sel    out  1  0=RF B, 1=immediate
//  ALU_func       out  4  0000 add, 0001 sub, 0010 and, 0011 or; R-type = Instr[3:0]
//  Mem_Req        out  1  data memory request, held until Mem_Ack
//  Mem_WrEn       out  1  data memory write (valid only with Mem_Req)
//  Illegal        out  1  1-cycle pulse in DEC on undefined opcode
//  Err            out  1  sticky memory-timeout fault
//  State          out  3  current state (debug)
// BEHAVIOUR
//  Opcode = Instr[31:26]: 100000 R-type, 110000 addi, 110010 andi, 110011 ori,
//   001111 lw, 011111 sw, 000000 beq, 000001 bne, 111111 b. Instr==0 is nop (not beq).
//  States: IF=0, DEC=1, EX=2, MEM=3, WB=4, ERR=5. Reset -> IF; Reset wins over all else.
//  All outputs are combinational from State/Instr; default 0. Reset cycle: all outputs 0, State=IF.
//  IF : Instr_LdEn=1 -> DEC.
//  DEC: nop or undefined -> PC_LdEn=1, PC_sel=0 -> IF (undefined also Illegal=1); else -> EX.
//  EX : ALU_func/ALU_Bin_sel/RF_B_sel driven. R-type: ALU_func=Instr[3:0], Bin=0.
//   addi/lw/sw: add, Bin=1. andi: and, Bin=1. ori: or, Bin=1. beq/bne: sub, Bin=0, RF_B_sel=1.
//   R/imm -> WB. lw/sw -> MEM. Branch: PC_LdEn=1, PC_sel=taken -> IF;
//   taken = b | (beq & Zero) | (bne & ~Zero).
//  MEM: Mem_Req=1 (Mem_WrEn=1 for sw), ALU add/Bin=1 held for address, RF_B_sel=1 for sw.
//   Stay until Mem_Ack. Ack: lw -> WB; sw -> PC_LdEn=1, PC_sel=0 -> IF.
//   Ack outside MEM ignored.
//  WB : RF_WrEn=1; RF_WrData_sel=1 for lw else 0; RF_B_sel=1 for imm/lw (dest Instr[20:16]);
//   PC_LdEn=1, PC_sel=0 -> IF.
//  Latency (cycles, no wait): nop 2, branch 3, R/imm 4, sw 4, lw 5; +1 per wait cycle in MEM.
//  PC_LdEn asserted exactly once per instruction; never with RF_WrEn for a branch.
//  Reset mid-MEM drops Mem_Req in the reset cycle; pending ack discarded.
// CONFIGURATION
//  CTRL_MEM_TIMEOUT_EN defined: counter clears on MEM entry; increments each MEM cycle
//   without Mem_Ack; when count == MEM_TIMEOUT-1 and no ack -> ERR. ERR: all enables 0,
//   Err=1, stays until Reset. Ack in the final cycle wins over timeout.
//  Undefined: MEM waits indefinitely; ERR unreachable; Err tied 0; no counter logic.
// TESTING
//  Reset 2 cycles -> State=0, all outputs 0; first post-reset cycle Instr_LdEn=1.
//  Instr=32'h0 -> IF,DEC; PC_LdEn=1, PC_sel=0 in DEC; RF_WrEn never 1.
//  R-type add (op 100000, func 0000) -> EX ALU_func=0000, Bin=0; WB RF_WrEn=1, WrData_sel=0; 4 cycles.
//  lw, Mem_Ack after 3 wait cycles -> Mem_Req=1 for 4 cycles, Mem_WrEn=0; WB WrData_sel=1; total 8.
//  beq Zero=1 -> EX PC_sel=1, PC_LdEn=1; bne Zero=1 -> PC_sel=0; b -> PC_sel=1; 3 cycles each.
//  Macro on, MEM_TIMEOUT=4, sw no ack -> ERR after 4 MEM cycles, Err=1 sticky; Reset clears.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle FSM controller sequencing the MIPS datapath (IF/DEC/EX/MEM/WB).
// Define CTRL_MEM_TIMEOUT_EN to add the sticky data-memory timeout fault (ERR state).
module multicycle_control
  #(parameter int MEM_TIMEOUT = 16)
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Mem_Ack,
  output logic        Instr_LdEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_Req,
  output logic        Mem_WrEn,
  output logic        Illegal,
  output logic        Err,
  output logic [2:0]  State
);
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DEC = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] w_op;
  logic       w_nop, w_rtype, w_addi, w_andi, w_ori, w_lw, w_sw;
  logic       w_beq, w_bne, w_b, w_imm, w_branch, w_undef, w_taken;

  assign w_op = Instr[31:26];

  // All-zero word is a nop even though its opcode field matches beq.
  always_comb begin
    w_nop   = (Instr == 32'h0);
    w_rtype = (w_op == 6'b100000);
    w_addi  = (w_op == 6'b110000);
    w_andi  = (w_op == 6'b110010);
    w_ori   = (w_op == 6'b110011);
    w_lw    = (w_op == 6'b001111);
    w_sw    = (w_op == 6'b011111);
    w_beq   = (w_op == 6'b000000) && !w_nop;
    w_bne   = (w_op == 6'b000001);
    w_b     = (w_op == 6'b111111);
    w_imm   = w_addi | w_andi | w_ori;
    w_branch = w_beq | w_bne | w_b;
    w_undef = !(w_nop | w_rtype | w_imm | w_lw | w_sw | w_branch);
    w_taken = w_b | (w_beq & Zero) | (w_bne & ~Zero);
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  // Counter is held at zero outside MEM, so every MEM visit starts from zero.
  always_ff @(posedge Clk) begin
    if (Reset || r_state != S_MEM) begin
      r_cnt <= '0;
    end else if (!Mem_Ack) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_cnt == TO_LAST) && !Mem_Ack;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset gates every output so a request in flight is dropped in the reset cycle.
  always_comb begin
    w_next        = r_state;
    Instr_LdEn    = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    Illegal       = 1'b0;
    Err           = 1'b0;
    State         = r_state;
    if (Reset) begin
      w_next = S_IF;
      State  = S_IF;
    end else begin
      case (r_state)
        S_IF: begin
          Instr_LdEn = 1'b1;
          w_next     = S_DEC;
        end
        S_DEC: begin
          if (w_nop || w_undef) begin
            PC_LdEn = 1'b1;
            Illegal = w_undef;
            w_next  = S_IF;
          end else begin
            w_next = S_EX;
          end
        end
        S_EX: begin
          ALU_Bin_sel = w_imm | w_lw | w_sw;
          RF_B_sel    = w_beq | w_bne;
          if (w_rtype)            ALU_func = Instr[3:0];
          else if (w_andi)        ALU_func = ALU_AND;
          else if (w_ori)         ALU_func = ALU_OR;
          else if (w_beq | w_bne) ALU_func = ALU_SUB;
          if (w_branch) begin
            PC_LdEn = 1'b1;
            PC_sel  = w_taken;
            w_next  = S_IF;
          end else if (w_lw || w_sw) begin
            w_next = S_MEM;
          end else begin
            w_next = S_WB;
          end
        end
        S_MEM: begin
          Mem_Req     = 1'b1;
          Mem_WrEn    = w_sw;
          ALU_Bin_sel = 1'b1;
          RF_B_sel    = w_sw;
          if (Mem_Ack) begin
            if (w_sw) begin
              PC_LdEn = 1'b1;
              w_next  = S_IF;
            end else begin
              w_next = S_WB;
            end
          end
`ifdef CTRL_MEM_TIMEOUT_EN
          else if (w_timeout) begin
            w_next = S_ERR;
          end
`endif
        end
        S_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = w_lw;
          RF_B_sel      = w_imm | w_lw;
          PC_LdEn       = 1'b1;
          w_next        = S_IF;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        S_ERR: begin
          Err = 1'b1;
        end
`endif
        default: w_next = S_IF;
      endcase
    end
  end
endmodule
